display_scan_mux: RTL and testbench
===================================

// Module: display_scan_mux
// PURPOSE
//  Time-multiplexed scanner for the common-anode 7-segment display: holds NDIG digit codes,
//  cycles one digit at a time, and feeds the selected 4-bit code to decoder7seg (digit codes
//  0-9, letters 12/13/14, blank 15). Drives anode enables and the active-low DP (seg bit 7).
//  Provides tear-free frame-synchronous updates, per-digit blink and an inter-digit dead time.
//  Sits between the timekeeping/menu logic (upstream) and decoder7seg (downstream).
// PARAMETERS
//  NDIG        4      number of digits scanned (>=2)
//  REFRESH_DIV 50000  clocks per digit slot (50 MHz -> 1 kHz/digit); must be > BLANK_CYC
//  BLANK_CYC   8      clocks at end of each slot with all anodes off (anti-ghosting), >=0
//  ANODE_ACT   1'b0   active level of o_anode bits (board uses PNP drivers -> low)
// PORTS
//  i_clk        in   1         system clock
//  i_rst        in   1         asynchronous, active-high reset
//  i_digits     in   4*NDIG    digit codes; [3:0] = digit 0 (rightmost)
//  i_dp_mask    in   NDIG      1 = decimal point lit on that digit
//  i_blink_mask in   NDIG      1 = digit participates in blinking
//  i_blink_ph   in   1         blink phase level from upstream; 1 = blinking digits dark
//  i_load       in   1         1-cycle strobe: capture i_digits/i_dp_mask into pending shadow
//  o_digit      out  4         code of current digit, to decoder7seg.i_digit
//  o_dp_n       out  1         active-low DP, merged into seg bit 7 at top level
//  o_anode      out  NDIG      one-hot (at ANODE_ACT) digit enable
//  o_frame_start out 1         1-cycle pulse, first output cycle of digit 0
// BEHAVIOUR
//  - Reset (async assert, sync release): cnt=0, idx=0, pending/active regs = all 4'hF codes,
//    dp masks 0, pend_vld=0; o_digit=4'hF, o_dp_n=1, o_anode all inactive, o_frame_start=0.
//  - Counters: cnt 0..REFRESH_DIV-1 increments every clock; at REFRESH_DIV-1 -> 0 and
//    idx <= (idx==NDIG-1) ? 0 : idx+1. Frame = NDIG*REFRESH_DIV clocks.
//  - Slot phases (2-state FSM per slot): ON while cnt < REFRESH_DIV-BLANK_CYC, else BLANK.
//    BLANK: all anodes inactive, o_digit=4'hF, o_dp_n=1. BLANK_CYC=0 -> BLANK never entered.
//  - ON: o_anode[idx]=ANODE_ACT, others inactive; o_digit=active[idx]; o_dp_n=~dp_act[idx].
//  - Blink: in ON, if i_blink_ph && i_blink_mask[idx] -> o_digit=4'hF, o_dp_n=1, anode still
//    driven. i_blink_ph sampled each cycle (no frame sync).
//  - All outputs registered: outputs reflect cnt/idx of previous cycle (1-cycle latency).
//  - Update: i_load copies i_digits/i_dp_mask to pending, pend_vld=1. When cnt==REFRESH_DIV-1
//    and idx==NDIG-1 (frame end), if pend_vld: active<=pending, pend_vld<=0.
//    Simultaneous i_load and frame end: active takes i_digits/i_dp_mask directly, pend_vld=0.
//    Multiple loads in one frame: last one wins. Displayed data never changes mid-frame.
//  - o_frame_start=1 exactly in the output cycle where digit 0 first appears (cnt=0,idx=0 lagged).
//  - Reset mid-frame: outputs go to reset values immediately (async), pending data discarded.
//  - Codes 10/11 passed through unchanged; decoder renders them blank.
// STRUCTURE
//  - Shared package clock_pkg: CODE_BLANK=4'hF, CODE_SEC=4'd12, CODE_MIN=4'd13,
//    CODE_HOUR=4'd14, NDIG_DEFAULT=4; also used by decoder7seg callers and menu logic.
//  - One sub-module: scan_timer (cnt/idx counters, outputs slot_on, slot_end, frame_end).
//    Shadow registers, blink and output muxing stay in display_scan_mux.
// TESTING (bench params: NDIG=4, REFRESH_DIV=8, BLANK_CYC=2, ANODE_ACT=0)
//  1 Reset, load digits 16'h1234 before first frame end -> after frame end each slot shows
//    6 cycles on + 2 blank; anodes 1110/1101/1011/0111 with o_digit 4,3,2,1; frame = 32 cycles.
//  2 o_frame_start pulses once per 32 cycles, coincident with o_anode=1110 first cycle.
//  3 i_load 16'h5678 at mid-frame -> digits 4,3,2,1 finish current frame; next frame shows 8,7,6,5;
//    i_load 16'h9999 exactly on frame-end cycle -> next frame shows 9 on all digits.
//  4 i_dp_mask=4'b0100, i_blink_mask=4'b0011, i_blink_ph=1 -> digits 0,1 o_digit=F, o_dp_n=1
//    with anode driven; digit 2 o_dp_n=0; i_blink_ph=0 -> digits 0,1 reappear.
//  5 Assert i_rst mid-slot -> same cycle o_anode=1111, o_digit=F, o_dp_n=1; after release
//    display blank (all F) until a load, scan restarts at digit 0.
//  6 BLANK_CYC=0 build -> anode held continuously, changes exactly at slot boundary, no gap.

Source files
------------

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared display codes and scan-slot phase type for the clock
//             display path (scanner, decoder callers, menu logic).
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

    // Digit codes understood by decoder7seg
    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_SEC   = 4'd12;
    localparam logic [3:0] CODE_MIN   = 4'd13;
    localparam logic [3:0] CODE_HOUR  = 4'd14;

    localparam int NDIG_DEFAULT = 4;

    // Phase within one digit slot: anode lit, or anti-ghosting dead time
    typedef enum logic [0:0] {
        SLOT_ON    = 1'b0,
        SLOT_BLANK = 1'b1
    } slot_phase_e;

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`default_nettype none
// ============================================================================
//  Module   : scan_timer
//  Purpose  : Slot/digit counters for the display scanner plus the per-slot
//             ON/BLANK phase machine.
//  Revision : 1.0  initial release
// ============================================================================
module scan_timer
    import clock_pkg::*;
#(
    parameter int NDIG        = NDIG_DEFAULT,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 8,
    parameter int IDX_W       = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_slot_on,
    output logic             o_slot_end,
    output logic             o_frame_end,
    output logic             o_frame_first
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);
    localparam bit               HAS_BLANK = (BLANK_CYC > 0);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    slot_phase_e      phase_q, phase_d;
    logic             slot_end;

    assign slot_end = (cnt_q == CNT_LAST);

    // Counter and phase state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            phase_q <= SLOT_ON;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
        end
    end

    // Next counter values and slot phase; BLANK covers the last BLANK_CYC counts
    always_comb begin
        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        phase_d = phase_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        case (phase_q)
            SLOT_ON:    if (HAS_BLANK && (cnt_q == ON_LAST)) phase_d = SLOT_BLANK;
            SLOT_BLANK: if (slot_end) phase_d = SLOT_ON;
            default:    phase_d = SLOT_ON;
        endcase
    end

    assign o_idx         = idx_q;
    assign o_slot_on     = (phase_q == SLOT_ON);
    assign o_slot_end    = slot_end;
    assign o_frame_end   = slot_end && (idx_q == IDX_LAST);
    assign o_frame_first = (cnt_q == '0) && (idx_q == '0);

endmodule
`default_nettype wire

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : display_scan_mux
//  Purpose  : Time-multiplexed 7-segment scanner with frame-synchronous digit
//             update, per-digit blink and inter-digit dead time. Feeds the
//             selected code to decoder7seg and drives the anode enables.
//  Revision : 1.0  initial release
// ============================================================================
module display_scan_mux
    import clock_pkg::*;
#(
    parameter int   NDIG        = NDIG_DEFAULT,
    parameter int   REFRESH_DIV = 50000,
    parameter int   BLANK_CYC   = 8,
    parameter logic ANODE_ACT   = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [4*NDIG-1:0] i_digits,
    input  logic [NDIG-1:0]   i_dp_mask,
    input  logic [NDIG-1:0]   i_blink_mask,
    input  logic              i_blink_ph,
    input  logic              i_load,
    output logic [3:0]        o_digit,
    output logic              o_dp_n,
    output logic [NDIG-1:0]   o_anode,
    output logic              o_frame_start
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [NDIG-1:0] ANODE_OFF = {NDIG{~ANODE_ACT}};
    localparam logic [NDIG-1:0] ONE_HOT0  = {{(NDIG-1){1'b0}}, 1'b1};

    logic [IDX_W-1:0] idx;
    logic             slot_on;
    logic             slot_end;
    logic             frame_end;
    logic             frame_first;

    scan_timer #(
        .NDIG        (NDIG),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC),
        .IDX_W       (IDX_W)
    ) u_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .o_idx         (idx),
        .o_slot_on     (slot_on),
        .o_slot_end    (slot_end),
        .o_frame_end   (frame_end),
        .o_frame_first (frame_first)
    );

    // Pending shadow (written on load) and active set (shown, swapped only at frame end)
    logic [NDIG-1:0][3:0] pend_dig_q;
    logic [NDIG-1:0]      pend_dp_q;
    logic                 pend_vld_q;
    logic [NDIG-1:0][3:0] act_dig_q;
    logic [NDIG-1:0]      act_dp_q;

    logic [3:0]      digit_q, digit_d;
    logic            dp_n_q, dp_n_d;
    logic [NDIG-1:0] anode_q, anode_d;
    logic            fstart_q;

    // Shadow capture and tear-free promotion at the last cycle of the frame
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_dig_q <= {NDIG{CODE_BLANK}};
            pend_dp_q  <= '0;
            pend_vld_q <= 1'b0;
            act_dig_q  <= {NDIG{CODE_BLANK}};
            act_dp_q   <= '0;
        end else begin
            if (i_load) begin
                pend_dig_q <= i_digits;
                pend_dp_q  <= i_dp_mask;
            end
            if (frame_end) begin
                // A load landing on the frame-end cycle bypasses the shadow
                if (i_load) begin
                    act_dig_q <= i_digits;
                    act_dp_q  <= i_dp_mask;
                end else if (pend_vld_q) begin
                    act_dig_q <= pend_dig_q;
                    act_dp_q  <= pend_dp_q;
                end
                pend_vld_q <= 1'b0;
            end else if (i_load) begin
                pend_vld_q <= 1'b1;
            end
        end
    end

    // Output selection for the current slot phase, digit and blink state
    always_comb begin
        digit_d = CODE_BLANK;
        dp_n_d  = 1'b1;
        anode_d = ANODE_OFF;
        if (slot_on) begin
            anode_d = ANODE_OFF ^ (ONE_HOT0 << idx);
            if (!(i_blink_ph && i_blink_mask[idx])) begin
                digit_d = act_dig_q[idx];
                dp_n_d  = ~act_dp_q[idx];
            end
        end
    end

    // Registered outputs, one cycle behind the counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            digit_q  <= CODE_BLANK;
            dp_n_q   <= 1'b1;
            anode_q  <= ANODE_OFF;
            fstart_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            dp_n_q   <= dp_n_d;
            anode_q  <= anode_d;
            fstart_q <= frame_first;
        end
    end

    assign o_digit       = digit_q;
    assign o_dp_n        = dp_n_q;
    assign o_anode       = anode_q;
    assign o_frame_start = fstart_q;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scan_mux
//  Purpose  : Self-checking bench for display_scan_mux (NDIG=4, REFRESH_DIV=8,
//             ANODE_ACT=0) with a BLANK_CYC=2 and a BLANK_CYC=0 instance
//             driven from the same inputs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_scan_mux;

    localparam int NDIG  = 4;
    localparam int RDIV  = 8;
    localparam int FRAME = NDIG * RDIV;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blink_mask;
    logic        blink_ph;
    logic        load;

    logic [3:0]  dig_a, anode_a, dig_b, anode_b;
    logic        dpn_a, fs_a, dpn_b, fs_b;

    always #5 clk = ~clk;

    display_scan_mux #(.NDIG(NDIG), .REFRESH_DIV(RDIV), .BLANK_CYC(2), .ANODE_ACT(1'b0)) dut (
        .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_dp_mask(dp_mask),
        .i_blink_mask(blink_mask), .i_blink_ph(blink_ph), .i_load(load),
        .o_digit(dig_a), .o_dp_n(dpn_a), .o_anode(anode_a), .o_frame_start(fs_a)
    );

    display_scan_mux #(.NDIG(NDIG), .REFRESH_DIV(RDIV), .BLANK_CYC(0), .ANODE_ACT(1'b0)) dut_nb (
        .i_clk(clk), .i_rst(rst), .i_digits(digits), .i_dp_mask(dp_mask),
        .i_blink_mask(blink_mask), .i_blink_ph(blink_ph), .i_load(load),
        .o_digit(dig_b), .o_dp_n(dpn_b), .o_anode(anode_b), .o_frame_start(fs_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int pos   = 0;   // scan position (clocks since reset release) of the cycle being driven

    // Reference model: every load and the frame from which it is displayed
    int          eff_q[$];
    logic [15:0] ld_dig_q[$];
    logic [3:0]  ld_dp_q[$];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @pos %0d: observed %h expected %h", tag, pos, obs, exp);
        end
    endtask

    // Latest load whose effective frame has been reached; all-blank otherwise
    function automatic void frame_data(input int f, output logic [15:0] d, output logic [3:0] m);
        d = 16'hFFFF;
        m = 4'b0000;
        foreach (eff_q[i]) begin
            if (eff_q[i] <= f) begin
                d = ld_dig_q[i];
                m = ld_dp_q[i];
            end
        end
    endfunction

    // Expected outputs for scan position p with b dead cycles per slot
    function automatic void expect_at(input int p, input int b, input logic [3:0] bm, input logic ph,
                                      output logic [3:0] ea, output logic [3:0] ed,
                                      output logic edp, output logic efs);
        int          slot, off;
        logic [15:0] d;
        logic [3:0]  m;
        slot = (p / RDIV) % NDIG;
        off  = p % RDIV;
        frame_data(p / FRAME, d, m);
        ea  = 4'hF;
        ed  = 4'hF;
        edp = 1'b1;
        efs = (p % FRAME == 0);
        if (off < RDIV - b) begin
            ea = 4'hF & ~(4'b0001 << slot);
            if (!(ph && bm[slot])) begin
                ed  = d[slot*4 +: 4];
                edp = ~m[slot];
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_anode"}, {4'h0, anode_a}, 8'h0F);
        chk({tag, "_digit"}, {4'h0, dig_a},   8'h0F);
        chk({tag, "_dpn"},   {7'h0, dpn_a},   8'h01);
        chk({tag, "_fs"},    {7'h0, fs_a},    8'h00);
        chk({tag, "_nb_anode"}, {4'h0, anode_b}, 8'h0F);
        chk({tag, "_nb_digit"}, {4'h0, dig_b},   8'h0F);
    endtask

    // One clock: called just after a falling edge, drives inputs, checks both DUTs
    task automatic step(input logic ld, input logic [15:0] dg, input logic [3:0] dpm);
        logic [3:0] ea, ed;
        logic       edp, efs;
        load    = ld;
        digits  = dg;
        dp_mask = dpm;
        if (ld) begin
            eff_q.push_back(pos / FRAME + 1);
            ld_dig_q.push_back(dg);
            ld_dp_q.push_back(dpm);
        end
        @(posedge clk);
        #1;
        expect_at(pos, 2, blink_mask, blink_ph, ea, ed, edp, efs);
        chk("anode", {4'h0, anode_a}, {4'h0, ea});
        chk("digit", {4'h0, dig_a},   {4'h0, ed});
        chk("dp_n",  {7'h0, dpn_a},   {7'h0, edp});
        chk("fstart", {7'h0, fs_a},   {7'h0, efs});
        expect_at(pos, 0, blink_mask, blink_ph, ea, ed, edp, efs);
        chk("nb_anode", {4'h0, anode_b}, {4'h0, ea});
        chk("nb_digit", {4'h0, dig_b},   {4'h0, ed});
        chk("nb_dp_n",  {7'h0, dpn_b},   {7'h0, edp});
        chk("nb_fstart", {7'h0, fs_b},   {7'h0, efs});
        pos++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'($urandom), 4'($urandom));
    endtask

    task automatic idle_until(input int frame_off);
        for (int i = 0; i < FRAME && (pos % FRAME) != frame_off; i++) idle(1);
    endtask

    task automatic model_reset();
        eff_q.delete();
        ld_dig_q.delete();
        ld_dp_q.delete();
        pos = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        load       = 1'b0;
        digits     = 16'h0;
        dp_mask    = 4'h0;
        blink_mask = 4'h0;
        blink_ph   = 1'b0;
        #1;
        check_reset_outputs("rst0");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Load 1234 well before the first frame end, then watch two frames
        idle(3);
        step(1'b1, 16'h1234, 4'h0);
        idle(2 * FRAME);

        // Mid-frame load: current frame keeps 1234, next one shows 5678
        idle_until(FRAME / 2);
        step(1'b1, 16'h5678, 4'h0);
        idle_until(FRAME - 1);
        idle(FRAME + 1);

        // Load exactly on the frame-end cycle takes effect in the very next frame
        idle_until(FRAME - 1);
        step(1'b1, 16'h9999, 4'h0);
        idle(FRAME);

        // Two loads in one frame: the later one wins
        idle_until(4);
        step(1'b1, 16'hABCD, 4'hF);
        idle(5);
        step(1'b1, 16'hE0C7, 4'b0100);
        idle_until(0);

        // Blink digits 0/1 with DP on digit 2, then release the blink phase
        blink_mask = 4'b0011;
        blink_ph   = 1'b1;
        idle(FRAME);
        blink_ph   = 1'b0;
        idle(FRAME);

        // Randomized traffic: sporadic loads, changing blink mask and phase
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) blink_ph = ~blink_ph;
            if ($urandom_range(0, 31) == 0) blink_mask = 4'($urandom);
            step(($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom));
        end
        blink_ph = 1'b0;

        // Pending load then asynchronous reset in the middle of a lit slot
        idle_until(RDIV + 1);
        step(1'b1, 16'h4321, 4'hF);
        idle_until(RDIV + 3);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("rst_async");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Blank until reloaded; scan restarts at digit 0
        idle(FRAME + 8);
        step(1'b1, 16'h2468, 4'b1001);
        idle(2 * FRAME);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
